sw_debounce: RTL and testbench
==============================

Name: sw_debounce

Overview:
Input-side counterpart of the LED output path. Samples raw board switches asynchronous to `clock` and synchronises them into the clock domain. Debounces each bit with a stability counter and emits the following:
- clean switch levels
- per-bit rise/fall pulses
- a one-deep change-event word with a valid/ready handshake, so a consumer (counter/shift-register control) can act on switch changes.

Parameters:
- NB_SW, 4, number of switch inputs.
- NB_COUNTER, 16, width of each per-bit stability counter.
- STABLE_CNT, 50000, consecutive cycles a synchronised bit must differ from its debounced level before the level updates. Legal range 1..2^NB_COUNTER-1; an elaboration-time check rejects other values.

Ports:
- clock, input, 1, system clock.
- i_reset, input, 1, synchronous active-low reset.
- i_sw, input, NB_SW, raw asynchronous switch levels.
- o_sw, output, NB_SW, debounced switch levels.
- o_rise, output, NB_SW, one-cycle pulse per bit on a debounced 0->1 transition.
- o_fall, output, NB_SW, one-cycle pulse per bit on a debounced 1->0 transition.
- o_valid, output, 1, change event pending.
- o_data, output, NB_SW, debounced word captured at the last change.
- i_ready, input, 1, consumer accepts the event when high together with o_valid.
- o_overrun, output, 1, sticky flag: an event was overwritten before it was accepted.

Behaviour:
- Reset: sampled at the rising edge of `clock` while i_reset=0. On that edge the following clear to 0:
  - synchroniser flops and counters
  - o_sw, o_rise, o_fall
  - o_valid, o_data, o_overrun
  - any pending event is discarded.
  Reset asserted mid-count or mid-handshake behaves identically.
- Synchroniser: two flops per bit; sync2 reflects i_sw two edges after sampling.
- Per-bit counter:
  - sync2 == o_sw bit: cnt <= 0.
  - mismatch and cnt < STABLE_CNT-1: cnt <= cnt+1.
  - mismatch and cnt == STABLE_CNT-1: o_sw bit <= sync2, cnt <= 0, and the matching o_rise/o_fall bit is 1 for exactly that next cycle.
- Latency: a clean input step appears on o_sw STABLE_CNT+2 edges after the first edge that samples it.
- Glitch rejection: a glitch shorter than STABLE_CNT synchronised cycles resets the counter and produces no output change and no pulse.
- Independent bits: bits debounce independently. Multiple bits may update in the same cycle; their pulses are then concurrent and a single event is generated.
- No wrap-around: cnt never exceeds STABLE_CNT-1.
- Event FSM, two states:
  - IDLE (o_valid=0) -> PEND when any bit of o_sw changes. o_data <= new o_sw, o_valid <= 1 on the next edge, i.e. the same cycle o_sw and the pulses update.
  - PEND, no change, i_ready=0: hold. o_data stable, o_valid=1.
  - PEND, no change, i_ready=1: transfer. Next state IDLE, o_valid <= 0.
  - PEND, change, i_ready=1 (simultaneous accept and new change): stay PEND, o_data <= new word, no overrun.
  - PEND, change, i_ready=0: overwrite. o_data <= new word, o_overrun <= 1.
- o_overrun clears only on reset.
- Power-up with a switch already high: after reset release it is reported as a rise pulse plus an event at STABLE_CNT+2 edges.

Decomposition:
- Shared package:
  - defaults for NB_SW and NB_COUNTER
  - the event-FSM state encoding (IDLE=1'b0, PEND=1'b1)
  - a function computing the legal maximum STABLE_CNT for a given NB_COUNTER.
- One natural sub-module, debounce_bit, instantiated NB_SW times via generate. It contains:
  - the 2-flop synchroniser
  - the stability counter
  - the level register
  - rise/fall pulse generation.
- The top level holds the event FSM, o_data and o_overrun.

Test Plan:
1. STABLE_CNT=4, i_sw=0000 through reset, i_reset=0 for 2 edges -> all outputs 0 on the edge after reset; still 0 after 20 idle cycles.
2. i_sw 0000->0101 held, i_ready=0 -> o_sw=0101 exactly 6 edges after the step is sampled; o_rise=0101 for one cycle; o_valid=1, o_data=0101, held; then i_ready=1 for one cycle -> o_valid=0 next cycle.
3. Bit0 high for 3 cycles then low (STABLE_CNT=4) -> o_sw, o_rise, o_fall and o_valid stay 0 throughout.
4. i_ready=0; step to 0001, then later to 0011 -> o_valid stays 1, o_data=0011, o_overrun=1 and remains 1 after acceptance.
5. Event pending with i_ready=1 in the same cycle a second debounced change (0011->0111) lands -> o_valid remains 1, o_data=0111, o_overrun stays 0.
6. Pending event, i_reset=0 for one edge while i_sw=1111 is held -> all outputs 0 next cycle; after release, o_rise=1111 and o_data=1111 at STABLE_CNT+2 edges.

Source files
------------

// File: rtl/sw_debounce_pkg.sv
// Shared definitions for the switch debouncer: default sizes, event-FSM
// encoding and the legal range helper for the stability threshold.
package sw_debounce_pkg;

  localparam int unsigned NB_SW_DEF      = 4;
  localparam int unsigned NB_COUNTER_DEF = 16;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } ev_state_t;

  // Largest threshold an NB_COUNTER-bit counter can reach before wrapping.
  function automatic longint unsigned max_stable_cnt(input int unsigned nb_counter);
    return (64'd1 << nb_counter) - 64'd1;
  endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: 2-flop synchroniser, stability counter, debounced level
// register and registered rise/fall pulses.
module sw_debounce_bit
  import sw_debounce_pkg::*;
#(
  parameter int unsigned NB_COUNTER = NB_COUNTER_DEF,
  parameter int unsigned STABLE_CNT = 50000
) (
  input  logic clock,
  input  logic i_reset,
  input  logic i_sw,
  output logic o_sw,
  output logic o_rise,
  output logic o_fall,
  output logic o_upd
);

  localparam logic [NB_COUNTER-1:0] CNT_LAST = NB_COUNTER'(STABLE_CNT - 1);

  logic                  r_sync1;
  logic                  r_sync2;
  logic                  r_level;
  logic                  r_rise;
  logic                  r_fall;
  logic [NB_COUNTER-1:0] r_cnt;
  logic                  w_diff;
  logic                  w_upd;

  // The level flips on the STABLE_CNT-th consecutive mismatching cycle.
  assign w_diff = r_sync2 ^ r_level;
  assign w_upd  = w_diff && (r_cnt == CNT_LAST);

  // NOTE: non-blocking assignments let r_sync2 take r_sync1's old value,
  // giving a real two-stage synchroniser instead of a single flop.
  always_ff @(posedge clock) begin
    if (!i_reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_sw;
      r_sync2 <= r_sync1;
      r_rise  <= w_upd & r_sync2;
      r_fall  <= w_upd & ~r_sync2;
      if (!w_diff || w_upd) r_cnt <= '0;
      else                  r_cnt <= r_cnt + NB_COUNTER'(1);
      if (w_upd) r_level <= r_sync2;
    end
  end

  assign o_sw   = r_level;
  assign o_rise = r_rise;
  assign o_fall = r_fall;
  assign o_upd  = w_upd;

endmodule

// File: rtl/sw_debounce.sv
// Debounced switch bank with rise/fall pulses and a one-deep change-event
// word offered to a consumer through a valid/ready handshake.
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int unsigned NB_SW      = NB_SW_DEF,
  parameter int unsigned NB_COUNTER = NB_COUNTER_DEF,
  parameter int unsigned STABLE_CNT = 50000
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic [NB_SW-1:0] i_sw,
  output logic [NB_SW-1:0] o_sw,
  output logic [NB_SW-1:0] o_rise,
  output logic [NB_SW-1:0] o_fall,
  output logic             o_valid,
  output logic [NB_SW-1:0] o_data,
  input  logic             i_ready,
  output logic             o_overrun
);

  if (STABLE_CNT == 0 || 64'(STABLE_CNT) > max_stable_cnt(NB_COUNTER)) begin : g_bad_cnt
    $error("sw_debounce: STABLE_CNT outside 1..2^NB_COUNTER-1");
  end

  logic [NB_SW-1:0] w_sw;
  logic [NB_SW-1:0] w_upd;
  logic             w_change;
  logic             w_set_ovr;
  ev_state_t        r_state;
  ev_state_t        w_state_next;
  logic [NB_SW-1:0] r_data;
  logic             r_overrun;

  for (genvar g = 0; g < NB_SW; g++) begin : g_bit
    sw_debounce_bit #(
      .NB_COUNTER (NB_COUNTER),
      .STABLE_CNT (STABLE_CNT)
    ) u_bit (
      .clock   (clock),
      .i_reset (i_reset),
      .i_sw    (i_sw[g]),
      .o_sw    (w_sw[g]),
      .o_rise  (o_rise[g]),
      .o_fall  (o_fall[g]),
      .o_upd   (w_upd[g])
    );
  end

  // Updates land on the same edge as o_sw, so the new word is o_sw ^ w_upd.
  assign w_change = |w_upd;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_set_ovr    = 1'b0;
    unique case (r_state)
      IDLE: if (w_change) w_state_next = PEND;
      PEND: begin
        if (w_change)     w_set_ovr    = !i_ready;
        else if (i_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!i_reset) begin
      r_state   <= IDLE;
      r_data    <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_change)  r_data    <= w_sw ^ w_upd;
      if (w_set_ovr) r_overrun <= 1'b1;
    end
  end

  assign o_sw      = w_sw;
  assign o_valid   = (r_state == PEND);
  assign o_data    = r_data;
  assign o_overrun = r_overrun;

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with STABLE_CNT=4: latency, glitch
// rejection, handshake, overrun and reset/power-up behaviour.
module tb_sw_debounce;

  localparam int NB_SW      = 4;
  localparam int NB_COUNTER = 16;
  localparam int STABLE_CNT = 4;
  localparam int LAT        = STABLE_CNT + 2;

  logic             clock   = 1'b0;
  logic             i_reset = 1'b0;
  logic             i_ready = 1'b0;
  logic [NB_SW-1:0] i_sw    = '0;
  logic [NB_SW-1:0] o_sw;
  logic [NB_SW-1:0] o_rise;
  logic [NB_SW-1:0] o_fall;
  logic             o_valid;
  logic [NB_SW-1:0] o_data;
  logic             o_overrun;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  sw_debounce #(
    .NB_SW      (NB_SW),
    .NB_COUNTER (NB_COUNTER),
    .STABLE_CNT (STABLE_CNT)
  ) dut (
    .clock     (clock),
    .i_reset   (i_reset),
    .i_sw      (i_sw),
    .o_sw      (o_sw),
    .o_rise    (o_rise),
    .o_fall    (o_fall),
    .o_valid   (o_valid),
    .o_data    (o_data),
    .i_ready   (i_ready),
    .o_overrun (o_overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_sw"},   32'(o_sw),      'b0);
    check({tag, "_rise"}, 32'(o_rise),    'b0);
    check({tag, "_fall"}, 32'(o_fall),    'b0);
    check({tag, "_vld"},  32'(o_valid),   'b0);
    check({tag, "_data"}, 32'(o_data),    'b0);
    check({tag, "_ovr"},  32'(o_overrun), 'b0);
  endtask

  initial begin
    // 1: reset, then idle
    tick(2);
    check_zero("t1_rst");
    i_reset = 1'b1;
    tick(20);
    check_zero("t1_idle");

    // 2: step to 0101, visible on the LAT-th edge counting the sampling edge
    i_sw = 4'b0101;
    tick(LAT - 1);
    check("t2_early_sw", 32'(o_sw), 'b0);
    tick(1);
    check("t2_sw",   32'(o_sw),    'b0101);
    check("t2_rise", 32'(o_rise),  'b0101);
    check("t2_fall", 32'(o_fall),  'b0);
    check("t2_vld",  32'(o_valid), 'b1);
    check("t2_data", 32'(o_data),  'b0101);
    tick(1);
    check("t2_rise_gone", 32'(o_rise),  'b0);
    tick(3);
    check("t2_hold_vld",  32'(o_valid), 'b1);
    check("t2_hold_data", 32'(o_data),  'b0101);
    i_ready = 1'b1;
    tick(1);
    i_ready = 1'b0;
    check("t2_accept_vld", 32'(o_valid), 'b0);

    // back to 0000: fall pulses and a new event
    i_sw = 4'b0000;
    tick(LAT);
    check("t2b_sw",   32'(o_sw),    'b0);
    check("t2b_fall", 32'(o_fall),  'b0101);
    check("t2b_vld",  32'(o_valid), 'b1);
    check("t2b_data", 32'(o_data),  'b0);
    i_ready = 1'b1;
    tick(1);
    i_ready = 1'b0;
    check("t2b_accept_vld", 32'(o_valid), 'b0);

    // 3: bit0 glitch of 3 cycles is rejected
    for (int i = 0; i < 12; i++) begin
      i_sw = (i < 3) ? 4'b0001 : 4'b0000;
      tick(1);
      check("t3_sw",   32'(o_sw),    'b0);
      check("t3_rise", 32'(o_rise),  'b0);
      check("t3_vld",  32'(o_valid), 'b0);
    end
    check("t3_ovr", 32'(o_overrun), 'b0);

    // 4: overwrite of an unaccepted event sets the sticky overrun
    i_sw = 4'b0001;
    tick(LAT);
    check("t4_a_data", 32'(o_data),    'b0001);
    check("t4_a_ovr",  32'(o_overrun), 'b0);
    i_sw = 4'b0011;
    tick(LAT);
    check("t4_b_sw",   32'(o_sw),      'b0011);
    check("t4_b_rise", 32'(o_rise),    'b0010);
    check("t4_b_vld",  32'(o_valid),   'b1);
    check("t4_b_data", 32'(o_data),    'b0011);
    check("t4_b_ovr",  32'(o_overrun), 'b1);
    i_ready = 1'b1;
    tick(1);
    i_ready = 1'b0;
    check("t4_acc_vld", 32'(o_valid),   'b0);
    check("t4_acc_ovr", 32'(o_overrun), 'b1);

    // reset with 0011 held: clears overrun, then power-up rise at LAT edges
    i_reset = 1'b0;
    tick(1);
    check_zero("t5_rst");
    i_reset = 1'b1;
    tick(LAT - 1);
    check("t5_pu_early", 32'(o_sw), 'b0);
    tick(1);
    check("t5_pu_rise", 32'(o_rise),  'b0011);
    check("t5_pu_vld",  32'(o_valid), 'b1);
    check("t5_pu_data", 32'(o_data),  'b0011);

    // 5: accept in the same cycle a new change lands
    i_sw = 4'b0111;
    tick(LAT - 1);
    check("t5_pend_data", 32'(o_data), 'b0011);
    i_ready = 1'b1;
    tick(1);
    i_ready = 1'b0;
    check("t5_vld",  32'(o_valid),   'b1);
    check("t5_data", 32'(o_data),    'b0111);
    check("t5_rise", 32'(o_rise),    'b0100);
    check("t5_ovr",  32'(o_overrun), 'b0);

    // 6: reset while an event is pending and 1111 is held
    i_sw = 4'b1111;
    tick(LAT);
    check("t6_pend_vld",  32'(o_valid), 'b1);
    check("t6_pend_data", 32'(o_data),  'b1111);
    i_reset = 1'b0;
    tick(1);
    check_zero("t6_rst");
    i_reset = 1'b1;
    tick(LAT - 1);
    check("t6_early_sw",  32'(o_sw),    'b0);
    check("t6_early_vld", 32'(o_valid), 'b0);
    tick(1);
    check("t6_sw",   32'(o_sw),      'b1111);
    check("t6_rise", 32'(o_rise),    'b1111);
    check("t6_vld",  32'(o_valid),   'b1);
    check("t6_data", 32'(o_data),    'b1111);
    check("t6_ovr",  32'(o_overrun), 'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
